// File: rtl/amp_sweep_pkg.sv
// ----------------------------------------------------------------------------
// amp_sweep_pkg
// Shared widths and FSM state encodings for the amplifier sweep sequencer.
// States are plain localparam constants so that older tools can also read
// them.
// ----------------------------------------------------------------------------
package amp_sweep_pkg;

    localparam int CODE_W  = 16;
    localparam int FLOAT_W = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_DUT_RST = 3'd1;
    localparam state_t ST_SETTLE  = 3'd2;
    localparam state_t ST_REPORT  = 3'd3;
    localparam state_t ST_FINISH  = 3'd4;

endpackage

// File: rtl/amp_sweep_ctrl_stab_detect.sv
// ----------------------------------------------------------------------------
// stab_detect
// Decides when the converter output has settled for the current code.
// Every sample_en_i strobe is counted. The first sample after clear_i only
// loads the reference. Each later sample is compared with the previous one.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   clear_i         clear the counters and forget the reference
//                   (held while the converter is in reset)
//   sample_en_i     one-cycle strobe: data_i is a valid sample
//   data_i          converter output word
//   stable_hit_o    this sample completes STABLE_COUNT equal pairs
//   timeout_hit_o   this sample is sample number TIMEOUT_SAMP
// Both hit outputs are combinational and describe the sample that is present
// now, so the caller can register the result on the same edge.
// ----------------------------------------------------------------------------
module stab_detect
    import amp_sweep_pkg::*;
#(
    parameter int STABLE_COUNT = 20,
    parameter int TIMEOUT_SAMP = 400
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_i,
    input  logic               sample_en_i,
    input  logic [FLOAT_W-1:0] data_i,
    output logic               stable_hit_o,
    output logic               timeout_hit_o
);

    localparam int EQW = $clog2(STABLE_COUNT + 1);
    localparam int SCW = $clog2(TIMEOUT_SAMP + 1);
    localparam logic [EQW-1:0] EQ_TGT = EQW'(STABLE_COUNT);
    localparam logic [SCW-1:0] SC_TGT = SCW'(TIMEOUT_SAMP);

    logic [FLOAT_W-1:0] ref_q;
    logic               have_ref_q;
    logic [EQW-1:0]     eq_cnt_q, eq_cnt_d;
    logic [SCW-1:0]     samp_cnt_q, samp_cnt_d;

    // Both counters saturate at their targets, so they cannot wrap if the
    // caller keeps strobing after a hit.
    always_comb begin
        eq_cnt_d   = eq_cnt_q;
        samp_cnt_d = samp_cnt_q;
        if (sample_en_i) begin
            samp_cnt_d = (samp_cnt_q == SC_TGT) ? samp_cnt_q : samp_cnt_q + 1'b1;
            if (!have_ref_q) begin
                eq_cnt_d = '0;
            end else if (data_i == ref_q) begin
                eq_cnt_d = (eq_cnt_q == EQ_TGT) ? eq_cnt_q : eq_cnt_q + 1'b1;
            end else begin
                eq_cnt_d = '0;
            end
        end
    end

    assign stable_hit_o  = sample_en_i && (eq_cnt_d == EQ_TGT);
    assign timeout_hit_o = sample_en_i && (samp_cnt_d == SC_TGT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_q      <= '0;
            have_ref_q <= 1'b0;
            eq_cnt_q   <= '0;
            samp_cnt_q <= '0;
        end else if (clear_i) begin
            have_ref_q <= 1'b0;
            eq_cnt_q   <= '0;
            samp_cnt_q <= '0;
        end else if (sample_en_i) begin
            ref_q      <= data_i;
            have_ref_q <= 1'b1;
            eq_cnt_q   <= eq_cnt_d;
            samp_cnt_q <= samp_cnt_d;
        end
    end

endmodule

// File: rtl/amp_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// amp_sweep_ctrl
// On-chip characterisation sequencer for the op-amp/IEEE-754 converter.
// The block steps the converter input code from code_first to code_last in
// increments of code_step. For each point it:
//   1. holds the converter in reset,
//   2. waits for the converter output to settle, or times out,
//   3. reports one result and waits for the consumer to accept it.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   start                             pulse to begin a sweep (ignored while busy)
//   code_first, code_step, code_last  sweep range, sampled on start
//   busy                              a sweep is in progress
//   done                              one-cycle pulse after the last result
//                                     is accepted
//   dut_rst_n, dut_in                 converter reset and input code
//   sample_en, dut_out                converter sample strobe and output word
//   res_valid, res_ready              result handshake
//   res_code, res_value, res_stable   result fields
// ----------------------------------------------------------------------------
module amp_sweep_ctrl
    import amp_sweep_pkg::*;
#(
    parameter int STABLE_COUNT = 20,
    parameter int TIMEOUT_SAMP = 400,
    parameter int RST_CYCLES   = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [CODE_W-1:0]  code_first,
    input  logic [CODE_W-1:0]  code_step,
    input  logic [CODE_W-1:0]  code_last,
    output logic               busy,
    output logic               done,
    output logic               dut_rst_n,
    output logic [CODE_W-1:0]  dut_in,
    input  logic               sample_en,
    input  logic [FLOAT_W-1:0] dut_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CODE_W-1:0]  res_code,
    output logic [FLOAT_W-1:0] res_value,
    output logic               res_stable
);

    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam logic [RCW-1:0] RC_TGT = RCW'(RST_CYCLES);

    state_t             state_q, state_d;
    logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [CODE_W-1:0]  step_q, step_d;
    logic [CODE_W-1:0]  last_q, last_d;
    logic [CODE_W-1:0]  dut_in_q, dut_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dut_rst_n_q, dut_rst_n_d;
    logic               res_valid_q, res_valid_d;
    logic [CODE_W-1:0]  res_code_q, res_code_d;
    logic [FLOAT_W-1:0] res_value_q, res_value_d;
    logic               res_stable_q, res_stable_d;
    logic [CODE_W:0]    next_code;
    logic               stable_hit, timeout_hit;

    stab_detect #(
        .STABLE_COUNT (STABLE_COUNT),
        .TIMEOUT_SAMP (TIMEOUT_SAMP)
    ) u_stab (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_i       (state_q == ST_DUT_RST),
        .sample_en_i   (sample_en && (state_q == ST_SETTLE)),
        .data_i        (dut_out),
        .stable_hit_o  (stable_hit),
        .timeout_hit_o (timeout_hit)
    );

    // The extra bit catches a carry out of the 16-bit code space.
    assign next_code = {1'b0, dut_in_q} + {1'b0, step_q};

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        step_d       = step_q;
        last_d       = last_q;
        dut_in_d     = dut_in_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        dut_rst_n_d  = dut_rst_n_q;
        res_valid_d  = res_valid_q;
        res_code_d   = res_code_q;
        res_value_d  = res_value_q;
        res_stable_d = res_stable_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    step_d    = code_step;
                    last_d    = code_last;
                    dut_in_d  = code_first;
                    busy_d    = 1'b1;
                    // The counter starts at 0 here. The start cycle therefore
                    // adds one cycle to the first reset pulse.
                    rst_cnt_d = '0;
                    state_d   = ST_DUT_RST;
                end
            end
            ST_DUT_RST: begin
                if (rst_cnt_q == RC_TGT) begin
                    dut_rst_n_d = 1'b1;
                    state_d     = ST_SETTLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (stable_hit || timeout_hit) begin
                    res_valid_d  = 1'b1;
                    res_code_d   = dut_in_q;
                    res_value_d  = dut_out;
                    res_stable_d = stable_hit;
                    state_d      = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if ((step_q == '0) || next_code[CODE_W] ||
                        (next_code[CODE_W-1:0] > last_q)) begin
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        dut_in_d    = next_code[CODE_W-1:0];
                        dut_rst_n_d = 1'b0;
                        // The handshake edge already drove dut_rst_n low, so
                        // the counter starts at 1 to give exactly RST_CYCLES
                        // low cycles.
                        rst_cnt_d   = RCW'(1);
                        state_d     = ST_DUT_RST;
                    end
                end
            end
            ST_FINISH: begin
                busy_d      = 1'b0;
                dut_rst_n_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            step_q       <= '0;
            last_q       <= '0;
            dut_in_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dut_rst_n_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_code_q   <= '0;
            res_value_q  <= '0;
            res_stable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            step_q       <= step_d;
            last_q       <= last_d;
            dut_in_q     <= dut_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dut_rst_n_q  <= dut_rst_n_d;
            res_valid_q  <= res_valid_d;
            res_code_q   <= res_code_d;
            res_value_q  <= res_value_d;
            res_stable_q <= res_stable_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign dut_rst_n  = dut_rst_n_q;
    assign dut_in     = dut_in_q;
    assign res_valid  = res_valid_q;
    assign res_code   = res_code_q;
    assign res_value  = res_value_q;
    assign res_stable = res_stable_q;

endmodule

// File: tb/tb_amp_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_amp_sweep_ctrl
// Bench for the sweep sequencer. A behavioural converter model drives
// sample_en every 4 clocks. Its output depends on the model mode and on the
// number of samples taken since dut_rst_n rose. Expected results are queued
// when each sweep starts and are popped on every result handshake.
// ----------------------------------------------------------------------------
module tb_amp_sweep_ctrl;

    localparam int RST_CYCLES = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] code_first = '0, code_step = '0, code_last = '0;
    logic        busy, done, dut_rst_n, res_valid, res_stable;
    logic [15:0] dut_in, res_code;
    logic [31:0] res_value;
    logic        sample_en = 1'b0;
    logic [31:0] dut_out = '0;
    logic        res_ready = 1'b1;

    always #5 clk = ~clk;

    amp_sweep_ctrl #(.STABLE_COUNT(20), .TIMEOUT_SAMP(400), .RST_CYCLES(RST_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .code_first(code_first), .code_step(code_step), .code_last(code_last),
        .busy(busy), .done(done), .dut_rst_n(dut_rst_n), .dut_in(dut_in),
        .sample_en(sample_en), .dut_out(dut_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_code(res_code), .res_value(res_value), .res_stable(res_stable)
    );

    typedef struct {
        logic [15:0] code;
        logic [31:0] value;
        logic        stable;
    } exp_t;

    exp_t sb_q[$];
    int   low_runs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   low_run  = 0;
    int   mode     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode 0: five distinct samples, then constant 0x45160000.
    // Mode 1: toggles between +1.0 and -1.0 on every sample.
    // Mode 2: five distinct samples, then a code-dependent constant.
    function automatic logic [31:0] model_val(input int m, input int idx, input logic [15:0] code);
        if (m == 0)      return (idx < 5) ? 32'h4500_0000 + 32'(idx) : 32'h4516_0000;
        else if (m == 1) return (idx % 2 == 1) ? 32'hBF80_0000 : 32'h3F80_0000;
        else             return (idx < 5) ? 32'(idx) * 32'h100 : {16'h4000, code};
    endfunction

    // Converter model. It is updated just after each rising edge. idx counts
    // samples since dut_rst_n rose.
    int   tick = 0;
    int   idx = 0;
    logic rst_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        tick++;
        if (!rst_prev) idx = 0;
        else if (sample_en) idx++;
        rst_prev  = dut_rst_n;
        sample_en = (tick % 4 == 0);
        dut_out   = model_val(mode, idx, dut_in);
    end

    // Scoreboard and pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", 64'(res_code), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("res_code", 64'(res_code), 64'(e.code));
                chk("res_value", 64'(res_value), 64'(e.value));
                chk("res_stable", 64'(res_stable), 64'(e.stable));
            end
        end
        if (done) done_cnt++;
        if (busy && !dut_rst_n) low_run++;
        else if (dut_rst_n && low_run != 0) begin
            low_runs.push_back(low_run);
            low_run = 0;
        end
        if (!busy) low_run = 0;
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_expected(input int first, input int step, input int last);
        int c, nxt;
        exp_t e;
        c = first;
        for (int k = 0; k < 70000; k++) begin
            e.code   = 16'(c);
            e.value  = (mode == 1) ? model_val(1, 399, 16'(c)) : model_val(mode, 100, 16'(c));
            e.stable = (mode != 1);
            sb_q.push_back(e);
            nxt = c + step;
            if (step == 0 || nxt > 65535 || nxt > last) break;
            c = nxt;
        end
    endtask

    task automatic pulse_start(input int first, input int step, input int last);
        code_first = 16'(first);
        code_step  = 16'(step);
        code_last  = 16'(last);
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc, d0;
        cyc = 0;
        d0  = done_cnt;
        while (!done && cyc < 20000) begin
            tick_n(1);
            cyc++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_res_valid_low_at_done"}, 64'(res_valid), 64'd0);
        tick_n(1);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, "_busy_after_done"}, 64'(busy), 64'd0);
        chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    // Runs one complete sweep with res_ready held high. start_lat counts the
    // cycles from the start edge to the first rise of dut_rst_n.
    task automatic run_sweep(input string tag, input int first, input int step, input int last,
                             input bit poke_start);
        int lat;
        push_expected(first, step, last);
        pulse_start(first, step, last);
        lat = 0;
        while (!dut_rst_n && lat < 100) begin
            tick_n(1);
            lat++;
        end
        chk({tag, "_start_lat"}, 64'(lat), 64'(RST_CYCLES + 1));
        if (poke_start) begin
            code_first = 16'd7777;
            start = 1'b1;
            tick_n(1);
            start = 1'b0;
        end
        wait_done(tag);
    endtask

    initial begin
        tick_n(3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dut_rst_n", 64'(dut_rst_n), 64'd0);
        chk("rst_dut_in", 64'(dut_in), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_code", 64'(res_code), 64'd0);
        chk("rst_res_value", 64'(res_value), 64'd0);
        chk("rst_res_stable", 64'(res_stable), 64'd0);
        reset_n = 1'b1;
        tick_n(3);

        // A single point that settles.
        mode = 0;
        run_sweep("single", 2400, 100, 2400, 1'b0);

        // Four points. A start pulse arrives while busy and must be ignored.
        mode = 2;
        low_runs.delete();
        run_sweep("sweep4", 100, 100, 400, 1'b1);
        chk("sweep4_rst_pulses", 64'(low_runs.size()), 64'd4);
        foreach (low_runs[i])
            chk("sweep4_rst_low_len", 64'(low_runs[i]), 64'((i == 0) ? RST_CYCLES + 1 : RST_CYCLES));
        tick_n(30);
        chk("ignored_start_no_sweep", 64'(busy), 64'd0);

        // An output that toggles on every sample hits the timeout.
        mode = 1;
        run_sweep("timeout", 3000, 1, 3000, 1'b0);

        // Back-pressure: the result and dut_in hold while res_ready is low.
        begin
            int   cyc;
            bit   ok;
            logic [31:0] cap_v;
            mode = 2;
            res_ready = 1'b0;
            push_expected(1000, 10, 1010);
            pulse_start(1000, 10, 1010);
            cyc = 0;
            while (!res_valid && cyc < 3000) begin
                tick_n(1);
                cyc++;
            end
            chk("hold_valid_seen", 64'(res_valid), 64'd1);
            cap_v = res_value;
            ok = 1'b1;
            for (int i = 0; i < 50; i++) begin
                tick_n(1);
                if (res_valid !== 1'b1 || res_code !== 16'd1000 || res_value !== cap_v ||
                    res_stable !== 1'b1 || dut_in !== 16'd1000)
                    ok = 1'b0;
            end
            chk("hold_fields_constant", 64'(ok), 64'd1);
            chk("hold_value", 64'(cap_v), 64'h4000_03E8);
            res_ready = 1'b1;
            wait_done("hold");
        end

        // Sweeps that stop after a single point.
        run_sweep("carry", 65500, 5000, 65535, 1'b0);
        run_sweep("step0", 50, 0, 1000, 1'b0);
        run_sweep("first_gt_last", 500, 10, 100, 1'b0);

        // Reset asserted during SETTLE.
        begin
            int d0;
            pulse_start(1234, 1, 1240);
            tick_n(RST_CYCLES + 20);
            chk("midrst_in_settle", 64'(dut_rst_n), 64'd1);
            d0 = done_cnt;
            reset_n = 1'b0;
            #1;
            chk("midrst_busy", 64'(busy), 64'd0);
            chk("midrst_dut_rst_n", 64'(dut_rst_n), 64'd0);
            chk("midrst_dut_in", 64'(dut_in), 64'd0);
            chk("midrst_res_valid", 64'(res_valid), 64'd0);
            chk("midrst_done", 64'(done), 64'd0);
            tick_n(3);
            reset_n = 1'b1;
            tick_n(300);
            chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
            chk("midrst_idle", 64'(busy), 64'd0);
        end

        // The block still works after the reset.
        run_sweep("after_rst", 42, 1, 42, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
